// File: rtl/aer_tx_handshake_if.sv
// Bundle between the channel request FSMs, the AER transmitter and the off-chip receiver.
// master = transmitter side, slave = channel FSMs plus receiver side.
interface aer_tx_handshake_if #(
    parameter int NCH = 2
) ();
    localparam int CH_W = $clog2(NCH);

    logic [NCH-1:0] go_ch;
    logic [NCH-1:0] up_ch;
    logic [NCH-1:0] req_ch;
    logic [NCH-1:0] fs_sen;
    logic [NCH-1:0] fe_d;
    logic           aer_req;
    logic [CH_W:0]  aer_addr;
    logic           aer_ack;
    logic           busy;
    logic           timeout_err;

    modport master (
        input  go_ch, up_ch, req_ch, aer_ack,
        output fs_sen, fe_d, aer_req, aer_addr, busy, timeout_err
    );

    modport slave (
        output go_ch, up_ch, req_ch, aer_ack,
        input  fs_sen, fe_d, aer_req, aer_addr, busy, timeout_err
    );
endinterface

// File: rtl/aer_tx_handshake.sv
// AER transmitter: grants one pending channel event and runs the four-phase REQ/ACK
// handshake, reporting sent/done back to the owning channel FSM.
//
// state   | meaning
// IDLE    | waiting for any go_ch with receiver ack low
// SETUP   | address driven, settling before req
// REQ     | launch req and fs_sen on the next edge
// WAIT_HI | req high, waiting for synchronised ack to rise
// WAIT_LO | req low, waiting for synchronised ack to fall
// DONE    | fe_d high until the channel drops its Req
module aer_tx_handshake #(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1023,
    parameter int SETUP_CYC   = 1
) (
    input  logic               clk,
    input  logic               reset,
    aer_tx_handshake_if.master bus
);
    localparam int CH_W    = $clog2(NCH);
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int SETUP_W = $clog2(SETUP_CYC + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] REQ     = 3'd2;
    localparam logic [2:0] WAIT_HI = 3'd3;
    localparam logic [2:0] WAIT_LO = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [CH_W-1:0]        sel_q, sel_d;
    logic [CH_W:0]          addr_q, addr_d;
    logic [SETUP_W-1:0]     setup_cnt_q, setup_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   abort_hi_q, abort_hi_d;
    logic                   tmo_err_q, tmo_err_d;
    logic                   aer_req_q, aer_req_d;
    logic                   busy_q, busy_d;
    logic [NCH-1:0]         fs_sen_q, fs_sen_d;
    logic [NCH-1:0]         fe_d_q, fe_d_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_s;

    assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], bus.aer_ack};
    assign ack_s      = ack_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        setup_cnt_d = setup_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        abort_hi_d  = abort_hi_q;
        tmo_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                abort_hi_d = 1'b0;
                // A receiver still holding ack high is not ready for a new request.
                if ((|bus.go_ch) && !ack_s) begin
                    for (int i = NCH - 1; i >= 0; i--) begin
                        if (bus.go_ch[i]) begin
                            sel_d  = CH_W'(i);
                            addr_d = {CH_W'(i), bus.up_ch[i]};
                        end
                    end
                    setup_cnt_d = SETUP_W'(SETUP_CYC - 1);
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_q == '0) state_d = REQ;
                else                   setup_cnt_d = setup_cnt_q - 1'b1;
            end
            REQ: begin
                tmo_cnt_d = TMO_W'(TIMEOUT_CYC - 1);
                state_d   = WAIT_HI;
            end
            WAIT_HI: begin
                if (ack_s) begin
                    tmo_cnt_d = TMO_W'(TIMEOUT_CYC - 1);
                    state_d   = WAIT_LO;
                end else if (tmo_cnt_q == '0) begin
                    tmo_err_d  = 1'b1;
                    abort_hi_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    state_d = DONE;
                end else if (tmo_cnt_q == '0) begin
                    tmo_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            DONE: begin
                // After an unanswered req, a late ack must also be seen to fall.
                if (!bus.req_ch[sel_q] && !(abort_hi_q && ack_s)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        aer_req_d = (state_d == WAIT_HI);
        busy_d    = (state_d != IDLE);
        fs_sen_d  = '0;
        fe_d_d    = '0;
        if (state_d == WAIT_HI || state_d == WAIT_LO) fs_sen_d[sel_q] = 1'b1;
        if (state_d == DONE)                          fe_d_d[sel_q]   = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            setup_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            abort_hi_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
            aer_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            fs_sen_q    <= '0;
            fe_d_q      <= '0;
            ack_sync_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            setup_cnt_q <= setup_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            abort_hi_q  <= abort_hi_d;
            tmo_err_q   <= tmo_err_d;
            aer_req_q   <= aer_req_d;
            busy_q      <= busy_d;
            fs_sen_q    <= fs_sen_d;
            fe_d_q      <= fe_d_d;
            ack_sync_q  <= ack_sync_d;
        end
    end

    assign bus.aer_req     = aer_req_q;
    assign bus.aer_addr    = addr_q;
    assign bus.fs_sen      = fs_sen_q;
    assign bus.fe_d        = fe_d_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = tmo_err_q;
endmodule
